serial_threshold_comparator: RTL and testbench

//  Bit-serial, multi-cycle magnitude comparator. Accepts an operand word and a threshold

---
 rtl/serial_threshold_comparator.sv | 169 ++++++++++++++++
 tb/tb_serial_threshold_comparator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_threshold_comparator.sv
// Bit-serial magnitude comparator.
// Captures an operand and a threshold, then scans them MSB-first one bit per
// clock and stops at the first bit where they differ. The result is a
// GT/LT/EQ verdict plus the number of bits scanned, held on a valid/ready
// output until the consumer takes it.
module serial_threshold_comparator #(
    parameter int WIDTH = 6,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_gt,
    output logic             o_lt,
    output logic             o_eq,
    output logic [CNT_W-1:0] o_nbits
);

    // A 1-bit index is kept even for WIDTH=1 so the register is never zero-width.
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] nbits_q, nbits_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic             accept;
    logic             release_out;
    logic             bit_a;
    logic             bit_b;
    logic             last_bit;

    assign accept      = (state_q == ST_IDLE) && i_valid;
    assign release_out = (state_q == ST_DONE) && i_ready;
    assign bit_a       = a_q[idx_q];
    assign bit_b       = b_q[idx_q];
    assign last_bit    = (idx_q == '0);

    // State register: reset returns to IDLE from anywhere, discarding any in-flight compare.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: the SCAN exit at idx==0 is unconditional, so idx cannot underflow.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if ((bit_a != bit_b) || last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (release_out) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are decoded from state alone.
    always_comb begin
        o_ready = (state_q == ST_IDLE);
        o_valid = (state_q == ST_DONE);
    end

    // Datapath next values: capture on accept, scan one bit per cycle, clear flags on release.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        nbits_d = nbits_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d   = i_a;
                    b_d   = i_b;
                    idx_d = IDX_W'(WIDTH - 1);
                    cnt_d = '0;
                end
            end
            ST_SCAN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_a && !bit_b) begin
                    gt_d    = 1'b1;
                    nbits_d = cnt_q + CNT_W'(1);
                end else if (!bit_a && bit_b) begin
                    lt_d    = 1'b1;
                    nbits_d = cnt_q + CNT_W'(1);
                end else if (last_bit) begin
                    eq_d    = 1'b1;
                    nbits_d = cnt_q + CNT_W'(1);
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (release_out) begin
                    gt_d = 1'b0;
                    lt_d = 1'b0;
                    eq_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, all cleared by reset so the block restarts from a known state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            nbits_q <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            nbits_q <= nbits_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    // Result outputs come straight from their registers.
    always_comb begin
        o_gt    = gt_q;
        o_lt    = lt_q;
        o_eq    = eq_q;
        o_nbits = nbits_q;
    end

endmodule

// File: tb/tb_serial_threshold_comparator.sv
// Self-checking bench for serial_threshold_comparator: directed cases, backpressure,
// mid-scan reset and an exhaustive sweep against a scoreboard of expected results.
module tb_serial_threshold_comparator;

    localparam int WIDTH = 6;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_valid;
    logic             i_ready;
    logic             o_gt;
    logic             o_lt;
    logic             o_eq;
    logic [CNT_W-1:0] o_nbits;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int gt;
        int lt;
        int eq;
        int nbits;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    serial_threshold_comparator #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_gt    (o_gt),
        .o_lt    (o_lt),
        .o_eq    (o_eq),
        .o_nbits (o_nbits)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_total++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference: decision falls on the highest bit where a and b differ.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   x;
        x       = a ^ b;
        e.gt    = (a > b) ? 1 : 0;
        e.lt    = (a < b) ? 1 : 0;
        e.eq    = (a == b) ? 1 : 0;
        e.nbits = WIDTH;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (x[i]) begin
                e.nbits = WIDTH - i;
                break;
            end
        end
        return e;
    endfunction

    // One request: drive, wait for the result, check it, optionally stall, then release.
    task automatic do_req(input int a, input int b, input int stall, input bit toggle);
        exp_t e;
        int   cyc;
        bit   got;
        @(negedge clk);
        chk("ready_idle", int'(o_ready), 1);
        i_a     = WIDTH'(a);
        i_b     = WIDTH'(b);
        i_valid = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < WIDTH + 3) begin
            @(negedge clk);
            cyc++;
            if (toggle) begin
                i_a = WIDTH'($urandom);
                i_b = WIDTH'($urandom);
            end
            if (o_valid) got = 1'b1;
        end
        e = sb.pop_front();
        chk("valid_timeout", int'(got), 1);
        if (got) begin
            chk("gt", int'(o_gt), e.gt);
            chk("lt", int'(o_lt), e.lt);
            chk("eq", int'(o_eq), e.eq);
            chk("nbits", int'(o_nbits), e.nbits);
            chk("latency", cyc, e.nbits + 1);
            chk("ready_done", int'(o_ready), 0);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("hold_valid", int'(o_valid), 1);
                chk("hold_ready", int'(o_ready), 0);
                chk("hold_gt", int'(o_gt), e.gt);
                chk("hold_lt", int'(o_lt), e.lt);
                chk("hold_eq", int'(o_eq), e.eq);
                chk("hold_nbits", int'(o_nbits), e.nbits);
            end
            i_ready = 1'b1;
            @(posedge clk);
            #1;
            i_ready = 1'b0;
            @(negedge clk);
            chk("rel_valid", int'(o_valid), 0);
            chk("rel_ready", int'(o_ready), 1);
            chk("rel_flags", int'({o_gt, o_lt, o_eq}), 0);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = '0;
        i_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b0;

        // Reset state, and IDLE holds with no request.
        @(negedge clk);
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_flags", int'({o_gt, o_lt, o_eq}), 0);
        chk("rst_nbits", int'(o_nbits), 0);
        repeat (3) @(negedge clk);
        chk("idle_hold_ready", int'(o_ready), 1);
        chk("idle_hold_valid", int'(o_valid), 0);

        // Directed cases.
        do_req(20, 19, 0, 1'b0);
        do_req(19, 19, 0, 1'b0);
        do_req(0, 19, 0, 1'b0);
        do_req(63, 19, 0, 1'b0);

        // Backpressure for 10 cycles in DONE.
        do_req(20, 19, 10, 1'b0);
        do_req(5, 19, 0, 1'b0);

        // Reset on the first SCAN cycle discards the compare.
        @(negedge clk);
        i_a     = WIDTH'(1);
        i_b     = WIDTH'(19);
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        chk("scan_ready", int'(o_ready), 0);
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready", int'(o_ready), 1);
        chk("midrst_valid", int'(o_valid), 0);
        chk("midrst_flags", int'({o_gt, o_lt, o_eq}), 0);
        chk("midrst_nbits", int'(o_nbits), 0);
        do_req(20, 19, 0, 1'b0);

        // Full sweep with inputs scrambled after the accept edge.
        for (int a = 0; a < (1 << WIDTH); a++) begin
            for (int b = 0; b < (1 << WIDTH); b++) begin
                do_req(a, b, 0, 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
